fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of FIFO read data and output stream data.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port fifo_empty, input, 1: empty flag from the upstream synch_fifo.
REQ-005 SHALL have port fifo_rd_en, output, 1: read strobe to the upstream FIFO's rd_en.
REQ-006 SHALL have port fifo_rd_data, input, DATA_WIDTH: FIFO read_data, valid the cycle after an accepted read.
REQ-007 SHALL have port m_valid, output, 1: output stream word valid.
REQ-008 SHALL have port m_ready, input, 1: downstream accepts the word.
REQ-009 SHALL have port m_data, output, DATA_WIDTH: output stream word, FIFO order.

Function
REQ-010 SHALL hold a 3-entry output buffer with occupancy occ (0..3) and an in-flight flag infl (read issued last cycle, data not yet captured).
REQ-011 SHALL drive fifo_rd_en = !fifo_empty && (occ + infl <= 2), using registered state only; there SHALL be no combinational path from m_ready to fifo_rd_en.
REQ-012 SHALL never assert fifo_rd_en while fifo_empty is 1.
REQ-013 SHALL set infl to the value of fifo_rd_en at each edge.
REQ-014 SHALL capture fifo_rd_data into the buffer tail at the edge ending a cycle where infl = 1.
REQ-015 SHALL drive m_valid = (occ != 0), with m_data equal to the buffer head, both from registers.
REQ-016 SHALL pop the head on an edge where m_valid && m_ready.
REQ-017 SHALL hold m_data stable while m_valid && !m_ready.
REQ-018 SHALL update occ' = occ + infl - pop; a simultaneous capture and pop SHALL leave occ unchanged and preserve order.
REQ-019 SHALL never overflow the buffer, since occ + infl <= 3 holds by construction.
REQ-020 SHALL have a latency from fifo_rd_en in cycle N to m_valid, with the buffer empty, of exactly 2 cycles (m_valid high in cycle N+2).
REQ-021 SHALL sustain one word per cycle when the FIFO is non-empty and m_ready is held at 1.
REQ-022 SHALL resume issuing reads within one cycle when m_ready deasserts then reasserts with occ = 3, losing or duplicating no word.

Reset
REQ-023 SHALL, on rst_n low, immediately set occ = 0, infl = 0, fifo_rd_en = 0, m_valid = 0 and m_data = 0.
REQ-024 SHALL, on reset mid-transfer, discard any in-flight or buffered words.
REQ-025 SHALL issue the first read no earlier than the first rising edge with rst_n high.

Configuration
REQ-026 SHALL, with macro FIFO_RD_CTRL_CNT_EN defined, add output rd_count[15:0]: count of m_valid && m_ready transfers, reset 0, saturating at 16'hFFFF.
REQ-027 SHALL, without FIFO_RD_CTRL_CNT_EN, have neither the port rd_count nor its counter logic.

Structure
REQ-028 SHALL place occupancy constants (BUF_DEPTH = 3) and the counter width in shared package fifo_pkg.
REQ-029 SHALL implement the 3-entry buffer as sub-module fifo_rd_skid (head/tail pointers, occ counter); the top holds the read-issue logic and infl.

Verification
REQ-030 SHALL cover single word: FIFO loaded with 8'hA0, m_ready = 1 -> fifo_rd_en one cycle, m_valid 2 cycles later with m_data = 8'hA0, then m_valid = 0.
REQ-031 SHALL cover streaming: 16 words 8'hA0..8'hAF in FIFO, m_ready = 1 -> 16 consecutive m_valid cycles, values in order, no bubbles after the first.
REQ-032 SHALL cover backpressure: 8'hC0..8'hC4 with m_ready = 0 -> exactly 3 reads issued, m_data = 8'hC0 held; after m_ready = 1 -> all 5 words appear in order.
REQ-033 SHALL cover the empty boundary: fifo_empty = 1 throughout -> fifo_rd_en never asserted and m_valid stays 0.
REQ-034 SHALL cover reset mid-stream: rst_n pulsed low with occ = 2 -> m_valid = 0 asynchronously; after release, the next word read from the FIFO is presented first.
REQ-035 SHALL cover the counter with FIFO_RD_CTRL_CNT_EN defined: 17 transfers -> rd_count = 17.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and pointer helper for the FIFO read controller
package fifo_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int PTR_W     = 2;
    localparam int OCC_W     = 2;
    localparam int CNT_WIDTH = 16;

    // Advance a buffer pointer, wrapping after the last entry
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 3-entry output buffer with head/tail pointers and occupancy
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  pop;

    // The head is only consumed when a word is actually presented
    assign pop   = valid && ready;
    assign valid = (occ != '0);
    assign data  = mem[head];

    // Capture at the tail, release at the head; occupancy tracks the difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read controller with output buffer; FIFO_RD_CTRL_CNT_EN adds rd_count
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CTRL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    logic             infl;
    logic             active;
    logic [OCC_W-1:0] occ;

    // Reads are issued from registered state only: buffer space counts the word already in flight,
    // and active holds reads off until the first clock edge after reset release
    assign fifo_rd_en = active && !fifo_empty && ((3'(occ) + 3'(infl)) <= 3'd2);

    // Track the read issued last cycle so its data is captured one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            infl   <= 1'b0;
        end else begin
            active <= 1'b1;
            infl   <= fifo_rd_en;
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl),
        .push_data (fifo_rd_data),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .occ       (occ)
    );

`ifdef FIFO_RD_CTRL_CNT_EN
    // Count accepted output words, holding at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else if (m_valid && m_ready && (rd_count != {CNT_WIDTH{1'b1}})) begin
            rd_count <= rd_count + 1'b1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed vector bench for fifo_rd_ctrl with a behavioural FIFO model
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
`ifdef FIFO_RD_CTRL_CNT_EN
    logic [15:0] rd_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Upstream FIFO model: read data appears the cycle after an accepted read
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
        end
    end

    fifo_rd_ctrl #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
`ifdef FIFO_RD_CTRL_CNT_EN
        ,
        .rd_count     (rd_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_words(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            mem[wr_ptr] = base + 8'(k);
            wr_ptr      = wr_ptr + 8'd1;
        end
    endtask

    typedef struct {
        int         n_push;
        logic [7:0] base;
        logic       rdy;
        logic       e_rd_en;
        logic       e_valid;
        logic [7:0] e_data;
        logic       chk_data;
    } vec_t;

    vec_t vt [16];

    initial begin
        int   first_c;
        int   got;
        int   found;
        logic [7:0] exp_w;

        // single word, then backpressure with five words
        vt[0]  = '{1, 8'hA0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        vt[1]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[2]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b1};
        vt[3]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[4]  = '{5, 8'hC0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[5]  = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[6]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC0, 1'b1};
        vt[7]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b1};
        vt[8]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b1};
        vt[9]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b1};
        vt[10] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b1};
        vt[11] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC1, 1'b1};
        vt[12] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC2, 1'b1};
        vt[13] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1};
        vt[14] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC4, 1'b1};
        vt[15] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        // reset state
        rst_n   = 1'b0;
        m_ready = 1'b0;
        push_words(1, 8'h11);
        #1;
        check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        check("reset_valid", 32'(m_valid), 32'd0);
        check("reset_data",  32'(m_data), 32'd0);
        @(negedge clk);
        check("reset_hold_rd_en", 32'(fifo_rd_en), 32'd0);
        rd_ptr = wr_ptr;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // table vectors
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            push_words(vt[i].n_push, vt[i].base);
            m_ready = vt[i].rdy;
            #1;
            check($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vt[i].e_rd_en));
            check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vt[i].e_valid));
            if (vt[i].chk_data)
                check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vt[i].e_data));
            check($sformatf("vec%0d_rd_when_empty", i), 32'(fifo_rd_en && fifo_empty), 32'd0);
        end

        // empty boundary
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            check("empty_rd_en", 32'(fifo_rd_en), 32'd0);
            check("empty_valid", 32'(m_valid), 32'd0);
        end

        // reset mid-stream with two words buffered and one in flight
        @(negedge clk);
        push_words(3, 8'hD0);
        m_ready = 1'b0;
        #1;
        check("mid_first_rd", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_valid_before", 32'(m_valid), 32'd1);
        check("mid_data_before", 32'(m_data), 32'hD0);
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", 32'(m_valid), 32'd0);
        check("mid_async_data", 32'(m_data), 32'd0);
        check("mid_async_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_words(1, 8'hD3);
        m_ready = 1'b1;
        #1;
        check("post_reset_no_early_rd", 32'(fifo_rd_en), 32'd0);
        found = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (m_valid) begin
                found = k;
                break;
            end
        end
        check("post_reset_latency", 32'(found), 32'd2);
        check("post_reset_first_word", 32'(m_data), 32'hD3);

        // streaming sixteen words
        @(negedge clk);
        push_words(16, 8'hA0);
        m_ready = 1'b1;
        first_c = -1;
        got     = 0;
        for (int c = 0; c < 40; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (m_valid) begin
                if (first_c < 0) first_c = c;
                exp_w = 8'hA0 + 8'(got);
                check("stream_data", 32'(m_data), 32'(exp_w));
                got++;
            end else if (got > 0 && got < 16) begin
                check("stream_bubble", 32'(got), 32'd16);
            end
        end
        check("stream_first_cycle", 32'(first_c), 32'd2);
        check("stream_count", 32'(got), 32'd16);

`ifdef FIFO_RD_CTRL_CNT_EN
        check("rd_count", 32'(rd_count), 32'd17);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
